// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared types, constants and board-building helpers for the 4x4 Sudoku engine
// Contents: state enum, cell/board types, base grid, difficulty masks, LFSR seed/taps,
// build_board (solution from random nibbles) and rotl16 (mask rotation).
package sudoku_pkg;

  typedef enum logic [3:0] {
    GEN_RAND  = 4'd0,
    SET_BOARD = 4'd1,
    SET_DIFF  = 4'd2,
    ROW       = 4'd3,
    COL       = 4'd4,
    VAL       = 4'd5,
    CHECK     = 4'd6,
    SOLVED    = 4'd7
  } state_e;

  typedef logic [2:0] cell_t;
  typedef logic [15:0][2:0] board_t;

  localparam logic [11:0] LFSR_SEED = 12'hACE;
  localparam logic [11:0] LFSR_TAPS = 12'hE08;

  localparam cell_t BASE_GRID [16] = '{
    3'd1, 3'd2, 3'd3, 3'd4,
    3'd3, 3'd4, 3'd1, 3'd2,
    3'd2, 3'd1, 3'd4, 3'd3,
    3'd4, 3'd3, 3'd2, 3'd1
  };

  localparam logic [15:0] BASE_MASK [4] = '{16'h7BDE, 16'h5BDA, 16'h5A5A, 16'h4A52};

  // Each output cell walks the transforms backwards (transpose, band swap,
  // column swap, row swap) to find its source cell, then relabels the value.
  function automatic board_t build_board(input logic [3:0] s, input logic [3:0] b);
    board_t g;
    logic [1:0] r, c, v;
    for (int i = 0; i < 16; i++) begin
      r = s[3] ? i[1:0] : i[3:2];
      c = s[3] ? i[3:2] : i[1:0];
      r = r ^ {b[1], 1'b0};
      c = (b[0] && !c[1]) ? c ^ 2'd1 : c;
      r = (s[2] && !r[1]) ? r ^ 2'd1 : r;
      v = BASE_GRID[{r, c}][1:0] - 2'd1 + s[1:0];
      g[i] = {1'b0, v} + 3'd1;
    end
    return g;
  endfunction

  function automatic logic [15:0] rotl16(input logic [15:0] m, input logic [3:0] a);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = m[4'(i) - a];
    return r;
  endfunction

endpackage

// File: rtl/sudoku_lfsr.sv
// sudoku_lfsr: 12-bit Fibonacci LFSR, free-running, seeded on synchronous reset
// Ports: clk_i clock, rst_i sync active-high reset, setup_o/a_o/b_o live bits [3:0]/[7:4]/[11:8].
module sudoku_lfsr
  import sudoku_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [3:0] setup_o,
  output logic [3:0] a_o,
  output logic [3:0] b_o
);
  logic [11:0] lfsr_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else lfsr_q <= {lfsr_q[10:0], ^(lfsr_q & LFSR_TAPS)};
  end
  assign setup_o = lfsr_q[3:0];
  assign a_o = lfsr_q[7:4];
  assign b_o = lfsr_q[11:8];
endmodule

// File: rtl/sudoku_top.sv
// sudoku_top: 4x4 Sudoku game engine (random solution, difficulty mask, entry FSM, solve check)
// Ports: in_clka clock, in_restart sync reset, in_new_game, in_enter, in_diff_cell_val;
// in_rand_* live LFSR nibbles (outputs), out_state + one-hot state flags, out_fill_flag,
// out_user_board_N / out_real_board_N per cell (i = row*4+col), out_solved.
module sudoku_top
  import sudoku_pkg::*;
(
  input  logic        in_clka,
  input  logic        in_restart,
  input  logic        in_new_game,
  input  logic        in_enter,
  input  logic [1:0]  in_diff_cell_val,
  output logic [3:0]  in_rand_setup,
  output logic [3:0]  in_rand_A,
  output logic [3:0]  in_rand_B,
  output logic [3:0]  out_state,
  output logic        out_gen_rand_flag,
  output logic        out_set_board_flag,
  output logic        out_set_diff_flag,
  output logic        out_row_flag,
  output logic        out_col_flag,
  output logic        out_val_flag,
  output logic        out_check_flag,
  output logic [15:0] out_fill_flag,
  output logic [2:0]  out_user_board_0,  output logic [2:0] out_user_board_1,
  output logic [2:0]  out_user_board_2,  output logic [2:0] out_user_board_3,
  output logic [2:0]  out_user_board_4,  output logic [2:0] out_user_board_5,
  output logic [2:0]  out_user_board_6,  output logic [2:0] out_user_board_7,
  output logic [2:0]  out_user_board_8,  output logic [2:0] out_user_board_9,
  output logic [2:0]  out_user_board_10, output logic [2:0] out_user_board_11,
  output logic [2:0]  out_user_board_12, output logic [2:0] out_user_board_13,
  output logic [2:0]  out_user_board_14, output logic [2:0] out_user_board_15,
  output logic [2:0]  out_real_board_0,  output logic [2:0] out_real_board_1,
  output logic [2:0]  out_real_board_2,  output logic [2:0] out_real_board_3,
  output logic [2:0]  out_real_board_4,  output logic [2:0] out_real_board_5,
  output logic [2:0]  out_real_board_6,  output logic [2:0] out_real_board_7,
  output logic [2:0]  out_real_board_8,  output logic [2:0] out_real_board_9,
  output logic [2:0]  out_real_board_10, output logic [2:0] out_real_board_11,
  output logic [2:0]  out_real_board_12, output logic [2:0] out_real_board_13,
  output logic [2:0]  out_real_board_14, output logic [2:0] out_real_board_15,
  output logic        out_solved
);
  state_e state_q, state_d;
  logic [3:0] setup_q, setup_d, a_q, a_d, b_q, b_d;
  logic [1:0] row_q, row_d, col_q, col_d;
  logic [15:0] fill_q, fill_d, mask;
  board_t real_q, real_d, user_q, user_d;

  sudoku_lfsr u_lfsr (
    .clk_i   (in_clka),
    .rst_i   (in_restart),
    .setup_o (in_rand_setup),
    .a_o     (in_rand_A),
    .b_o     (in_rand_B)
  );

  assign mask = rotl16(BASE_MASK[in_diff_cell_val], a_q);

  always_comb begin
    state_d = state_q;
    setup_d = setup_q;
    a_d = a_q;
    b_d = b_q;
    row_d = row_q;
    col_d = col_q;
    fill_d = fill_q;
    real_d = real_q;
    user_d = user_q;
    if (in_new_game) state_d = GEN_RAND;
    else begin
      case (state_q)
        GEN_RAND: begin
          setup_d = in_rand_setup;
          a_d = in_rand_A;
          b_d = in_rand_B;
          state_d = SET_BOARD;
        end
        SET_BOARD: begin
          real_d = build_board(setup_q, b_q);
          user_d = '0;
          fill_d = '0;
          state_d = SET_DIFF;
        end
        SET_DIFF: if (in_enter) begin
          fill_d = mask;
          for (int i = 0; i < 16; i++) user_d[i] = mask[i] ? real_q[i] : 3'd0;
          state_d = ROW;
        end
        ROW: if (in_enter) begin
          row_d = in_diff_cell_val;
          state_d = COL;
        end
        COL: if (in_enter) begin
          col_d = in_diff_cell_val;
          state_d = VAL;
        end
        VAL: if (in_enter) begin
          if (!fill_q[{row_q, col_q}]) user_d[{row_q, col_q}] = {1'b0, in_diff_cell_val} + 3'd1;
          state_d = CHECK;
        end
        CHECK: state_d = (user_q == real_q) ? SOLVED : ROW;
        SOLVED: state_d = SOLVED;
        default: state_d = GEN_RAND;
      endcase
    end
  end

  always_ff @(posedge in_clka) begin
    if (in_restart) begin
      state_q <= GEN_RAND;
      setup_q <= '0;
      a_q <= '0;
      b_q <= '0;
      row_q <= '0;
      col_q <= '0;
      fill_q <= '0;
      real_q <= '0;
      user_q <= '0;
    end else begin
      state_q <= state_d;
      setup_q <= setup_d;
      a_q <= a_d;
      b_q <= b_d;
      row_q <= row_d;
      col_q <= col_d;
      fill_q <= fill_d;
      real_q <= real_d;
      user_q <= user_d;
    end
  end

  assign out_state = state_q;
  assign out_gen_rand_flag = state_q == GEN_RAND;
  assign out_set_board_flag = state_q == SET_BOARD;
  assign out_set_diff_flag = state_q == SET_DIFF;
  assign out_row_flag = state_q == ROW;
  assign out_col_flag = state_q == COL;
  assign out_val_flag = state_q == VAL;
  assign out_check_flag = state_q == CHECK;
  assign out_solved = state_q == SOLVED;
  assign out_fill_flag = fill_q;

  assign out_user_board_0 = user_q[0];   assign out_real_board_0 = real_q[0];
  assign out_user_board_1 = user_q[1];   assign out_real_board_1 = real_q[1];
  assign out_user_board_2 = user_q[2];   assign out_real_board_2 = real_q[2];
  assign out_user_board_3 = user_q[3];   assign out_real_board_3 = real_q[3];
  assign out_user_board_4 = user_q[4];   assign out_real_board_4 = real_q[4];
  assign out_user_board_5 = user_q[5];   assign out_real_board_5 = real_q[5];
  assign out_user_board_6 = user_q[6];   assign out_real_board_6 = real_q[6];
  assign out_user_board_7 = user_q[7];   assign out_real_board_7 = real_q[7];
  assign out_user_board_8 = user_q[8];   assign out_real_board_8 = real_q[8];
  assign out_user_board_9 = user_q[9];   assign out_real_board_9 = real_q[9];
  assign out_user_board_10 = user_q[10]; assign out_real_board_10 = real_q[10];
  assign out_user_board_11 = user_q[11]; assign out_real_board_11 = real_q[11];
  assign out_user_board_12 = user_q[12]; assign out_real_board_12 = real_q[12];
  assign out_user_board_13 = user_q[13]; assign out_real_board_13 = real_q[13];
  assign out_user_board_14 = user_q[14]; assign out_real_board_14 = real_q[14];
  assign out_user_board_15 = user_q[15]; assign out_real_board_15 = real_q[15];
endmodule

// File: tb/tb_sudoku_top.sv
// tb_sudoku_top: directed self-checking bench for sudoku_top
module tb_sudoku_top;
  logic clk = 1'b0;
  logic restart, new_game, enter;
  logic [1:0] dv;
  wire [3:0] r_setup, r_a, r_b, state;
  wire f_gen, f_board, f_diff, f_row, f_col, f_val, f_check, solved;
  wire [15:0] fill;
  wire [15:0][2:0] ub, rb;
  int n_cmp = 0;
  int n_err = 0;
  int b1 [16] = '{4, 2, 1, 3, 3, 1, 2, 4, 2, 4, 3, 1, 1, 3, 4, 2};
  int b2 [16] = '{3, 1, 4, 2, 4, 2, 3, 1, 1, 3, 2, 4, 2, 4, 1, 3};
  logic [15:0][2:0] exp1, exp2;

  always #5 clk = ~clk;

  sudoku_top dut (
    .in_clka(clk), .in_restart(restart), .in_new_game(new_game), .in_enter(enter),
    .in_diff_cell_val(dv), .in_rand_setup(r_setup), .in_rand_A(r_a), .in_rand_B(r_b),
    .out_state(state), .out_gen_rand_flag(f_gen), .out_set_board_flag(f_board),
    .out_set_diff_flag(f_diff), .out_row_flag(f_row), .out_col_flag(f_col),
    .out_val_flag(f_val), .out_check_flag(f_check), .out_fill_flag(fill),
    .out_user_board_0(ub[0]), .out_user_board_1(ub[1]), .out_user_board_2(ub[2]),
    .out_user_board_3(ub[3]), .out_user_board_4(ub[4]), .out_user_board_5(ub[5]),
    .out_user_board_6(ub[6]), .out_user_board_7(ub[7]), .out_user_board_8(ub[8]),
    .out_user_board_9(ub[9]), .out_user_board_10(ub[10]), .out_user_board_11(ub[11]),
    .out_user_board_12(ub[12]), .out_user_board_13(ub[13]), .out_user_board_14(ub[14]),
    .out_user_board_15(ub[15]),
    .out_real_board_0(rb[0]), .out_real_board_1(rb[1]), .out_real_board_2(rb[2]),
    .out_real_board_3(rb[3]), .out_real_board_4(rb[4]), .out_real_board_5(rb[5]),
    .out_real_board_6(rb[6]), .out_real_board_7(rb[7]), .out_real_board_8(rb[8]),
    .out_real_board_9(rb[9]), .out_real_board_10(rb[10]), .out_real_board_11(rb[11]),
    .out_real_board_12(rb[12]), .out_real_board_13(rb[13]), .out_real_board_14(rb[14]),
    .out_real_board_15(rb[15]),
    .out_solved(solved)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic st_chk(input string tag, input logic [3:0] s);
    chk({tag, " state"}, state, s);
    chk({tag, " flags"}, {solved, f_check, f_val, f_col, f_row, f_diff, f_board, f_gen}, 8'b1 << s);
  endtask

  task automatic chk_reset(input string tag);
    st_chk(tag, 4'd0);
    chk({tag, " rand"}, {r_b, r_a, r_setup}, 12'hACE);
    chk({tag, " user"}, ub, 48'd0);
    chk({tag, " real"}, rb, 48'd0);
    chk({tag, " fill"}, fill, 16'd0);
  endtask

  function automatic logic [47:0] masked(input logic [47:0] b, input logic [15:0] f);
    logic [47:0] m;
    for (int i = 0; i < 16; i++) m[i*3 +: 3] = f[i] ? b[i*3 +: 3] : 3'd0;
    return m;
  endfunction

  function automatic logic valid(input logic [15:0][2:0] b);
    logic ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] rw = '0, cl = '0, bx = '0;
      for (int j = 0; j < 4; j++) begin
        rw |= 8'b1 << b[k*4 + j];
        cl |= 8'b1 << b[j*4 + k];
        bx |= 8'b1 << b[((k/2)*2 + j/2)*4 + (k%2)*2 + j%2];
      end
      ok &= (rw == 8'h1E) && (cl == 8'h1E) && (bx == 8'h1E);
    end
    return ok;
  endfunction

  task automatic entry(input logic [1:0] r, input logic [1:0] c, input logic [1:0] v,
                       input logic [3:0] fin);
    enter = 1'b1;
    dv = r;
    step;
    st_chk("row->col", 4'd4);
    dv = c;
    step;
    st_chk("col->val", 4'd5);
    dv = v;
    step;
    st_chk("val->check", 4'd6);
    enter = 1'b0;
    step;
    st_chk("check->", fin);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      exp1[i] = 3'(b1[i]);
      exp2[i] = 3'(b2[i]);
    end
    restart = 1'b1; new_game = 1'b0; enter = 1'b0; dv = 2'd0;
    step;
    chk_reset("reset");
    restart = 1'b0;
    step;
    st_chk("set_board", 4'd1);
    step;
    st_chk("set_diff", 4'd2);
    chk("real1", rb, exp1);
    chk("real1 valid", valid(rb), 1'b1);
    chk("user cleared", ub, 48'd0);
    dv = 2'd3; enter = 1'b1;
    step;
    enter = 1'b0;
    st_chk("d3", 4'd3);
    chk("fill d3", fill, 16'h24A5);
    chk("ones d3", $countones(fill), 6);
    chk("user d3", ub, masked(exp1, 16'h24A5));
    restart = 1'b1;
    step;
    restart = 1'b0;
    step;
    step;
    st_chk("diff again", 4'd2);
    dv = 2'd0; enter = 1'b1;
    step;
    enter = 1'b0;
    st_chk("d0", 4'd3);
    chk("fill d0", fill, 16'hE7BD);
    chk("ones d0", $countones(fill), 12);
    chk("user d0", ub, masked(exp1, 16'hE7BD));
    new_game = 1'b1;
    step;
    new_game = 1'b0;
    st_chk("new game", 4'd0);
    step;
    step;
    st_chk("ng diff", 4'd2);
    chk("real2", rb, exp2);
    chk("real2 valid", valid(rb), 1'b1);
    chk("real2 differs", rb != exp1, 1'b1);
    chk("ng user cleared", ub, 48'd0);
    chk("ng fill cleared", fill, 16'd0);
    restart = 1'b1; new_game = 1'b1;
    step;
    chk_reset("rst+ng");
    restart = 1'b0; new_game = 1'b0;
    step;
    step;
    dv = 2'd0; enter = 1'b1;
    step;
    enter = 1'b0;
    st_chk("play d0", 4'd3);
    entry(2'd1, 2'd2, 2'd3, 4'd3);
    chk("cell6 wrong", ub[6], 3'd4);
    entry(2'd0, 2'd0, 2'd0, 4'd3);
    chk("given kept", ub[0], 3'd4);
    entry(2'd1, 2'd2, 2'd1, 4'd3);
    chk("cell6 fixed", ub[6], 3'd2);
    entry(2'd0, 2'd1, 2'd1, 4'd3);
    entry(2'd2, 2'd3, 2'd0, 4'd3);
    entry(2'd3, 2'd0, 2'd0, 4'd7);
    chk("solved board", ub, exp1);
    enter = 1'b1; dv = 2'd2;
    repeat (3) step;
    st_chk("solved hold", 4'd7);
    chk("solved hold user", ub, exp1);
    enter = 1'b0;
    restart = 1'b1;
    step;
    restart = 1'b0;
    step;
    step;
    enter = 1'b1; dv = 2'd0;
    step;
    dv = 2'd1;
    step;
    st_chk("mid col", 4'd4);
    restart = 1'b1;
    step;
    chk_reset("mid reset");
    restart = 1'b0; enter = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sudoku_top.md
# sudoku_top

Top level of the 4×4 Sudoku game engine. An internal LFSR supplies random nibbles. They are used to build a valid solution grid (the real board) and a difficulty-dependent set of revealed cells (the user board). A Moore FSM then takes row, column and value entries one per `in_enter` and declares the puzzle solved when the user board equals the real board. All board contents and status flags are exported for display and verification.

## Interface
- No parameters; constants live in the package.
- `in_clka` in 1: the single clock, rising edge.
- `in_restart` in 1: synchronous active-high reset.
- `in_new_game` in 1: start a new puzzle without re-seeding the LFSR.
- `in_enter` in 1: level-sensitive; accepts `in_diff_cell_val` in waiting states.
- `in_diff_cell_val` in 2: difficulty, row, column, or value−1, depending on state.
- `in_rand_setup`, `in_rand_A`, `in_rand_B` out 4 each: live LFSR bits [3:0], [7:4], [11:8] (outputs despite the `in_` prefix).
- `out_state` out 4: FSM state code.
- `out_gen_rand_flag`, `out_set_board_flag`, `out_set_diff_flag`, `out_row_flag`, `out_col_flag`, `out_val_flag`, `out_check_flag` out 1 each: high while in the matching state.
- `out_fill_flag` out 16: bit i=1 means cell i is a given and is not editable.
- `out_user_board_0..15` out 3 each: player board; 0=empty, 1–4=value.
- `out_real_board_0..15` out 3 each: solution; values 1–4.
- `out_solved` out 1: high in the SOLVED state.
- Cell index i = row*4 + col.

## Operation
- LFSR:
  - 12 bits, seed 12'hACE on reset.
  - Every cycle: shift left, bit0 = l[11]^l[10]^l[9]^l[3].
  - Runs in every state.
- States:
  - GEN_RAND=0: latch setup/A/B nibbles; then go to SET_BOARD.
  - SET_BOARD=1: real board ← transformed base grid; clear the user board and fill flags; then go to SET_DIFF.
  - SET_DIFF=2: wait for enter. On enter, difficulty d = input; mask = base_mask[d] rotated left by A; fill_flag = mask; user[i] = real[i] where mask[i], else 0. Then go to ROW.
  - ROW=3: on enter, latch row; go to COL.
  - COL=4: on enter, latch col; go to VAL.
  - VAL=5: on enter, user[row*4+col] ← input+1 unless fill_flag is set (write ignored); go to CHECK.
  - CHECK=6: if all 16 user cells equal the real cells, go to SOLVED; else go to ROW.
  - SOLVED=7: hold.
  - Codes 8–15 are unused; any unused code goes to GEN_RAND.
- Base grid rows: 1234 / 3412 / 2143 / 4321.
- Transforms, applied in this order:
  1. Relabel: v' = ((v−1+setup[1:0]) mod 4)+1.
  2. If setup[2], swap rows 0 and 1.
  3. If B[0], swap columns 0 and 1.
  4. If B[1], swap the row bands {0,1} and {2,3}.
  5. If setup[3], transpose.
- Every transform preserves row, column and 2×2-box validity.
- base_mask: d=0 16'h7BDE (12 givens), 1 16'h5BDA (10), 2 16'h5A5A (8), 3 16'h4A52 (6).

## Timing
- All updates occur on the rising edge of `in_clka`.
- Priority: `in_restart` > `in_new_game` > `in_enter`.
- Reset:
  - LFSR = ACE; state = GEN_RAND (`out_gen_rand_flag`=1).
  - Boards, fill flags, latches = 0; `out_solved` = 0.
- `in_new_game` in any state: next state is GEN_RAND; the LFSR keeps running; boards are rebuilt in the following two cycles.
- Startup timing: GEN_RAND and SET_BOARD take one cycle each, so SET_DIFF is entered 2 cycles after reset or new game.
- Each entry takes one cycle per state; entering with `in_enter` held high is allowed.
- CHECK lasts exactly one cycle and ignores `in_enter`.
- Flags and `out_solved` are Moore outputs, decoded from the state register.
- In SOLVED, only restart or new game leaves the state.

## Structure
- Package `sudoku_pkg` holds:
  - state enum (4-bit);
  - base grid;
  - base_mask[4];
  - LFSR seed and taps;
  - 3-bit cell type.
- Sub-module `sudoku_lfsr`: 12-bit LFSR with synchronous reset; outputs the three nibbles.
- Boards are arrays of 16×3 bits, unpacked to the individual ports at the top.

## Test plan
- Reset, then release:
  - First cycle: state 0, `in_rand_setup`=E, A=C, B=A, all boards 0.
  - Next cycle: state 1, then 2.
  - The real board satisfies all Sudoku constraints.
- In SET_DIFF, enter d=0 → `out_fill_flag` has 12 ones; user equals real on those cells and is 0 elsewhere. Repeat for d=3 → 6 ones.
- Enter row=1, col=2, val=11 on a non-given cell:
  - state sequence 3→4→5→6→3;
  - `out_user_board_6` = 4;
  - writing a given cell leaves it unchanged.
- Enter the correct values into every empty cell → CHECK goes to state 7, `out_solved`=1 and holds with `in_enter` high.
- Pulse `in_new_game` in ROW → state 0, then a new real board that differs from the previous one for the same seed run; assert `in_restart` together with `in_new_game` → reset values.
- Assert `in_restart` mid-entry in state 4 → the next cycle shows full reset values, and the LFSR restarts at ACE.
